sar_search_controller: RTL and testbench

- Successive-approximation (binary-search) controller on the initiator side of the team's (N+1)-bit magnitude comparator.
- Drives a trial value onto the comparator's y input while the unknown value sits on its x input. Consumes the xgty/xlty/xeqy flags and resolves x MSB-first.
- Used for SAR-style value recovery and threshold search. It reports the recovered value with a done pulse.

---
 rtl/sar_search_controller_if.sv | 28 ++
 rtl/sar_search_controller.sv | 124 ++++++++++++
 tb/tb_sar_search_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_controller_if.sv
// Bundles the SAR controller's request/result signals and the comparator link
// into one port group; the controller takes the master side.
interface sar_search_controller_if #(
    parameter int N = 3
);
    // start is a level request sampled only while the controller is idle;
    // done is a single-cycle pulse marking result/err valid, which stay held
    // until the next accepted start. There is no ready/back-pressure path.
    logic       start;
    logic [N:0] trial;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       cmp_eq;
    logic       busy;
    logic       done;
    logic [N:0] result;
    logic       err;

    modport master (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output trial, busy, done, result, err
    );

    modport slave (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  trial, busy, done, result, err
    );
endinterface

// File: rtl/sar_search_controller.sv
// Successive-approximation controller: drives trial values into a magnitude
// comparator and resolves the unknown MSB-first, reporting it with a done pulse.
module sar_search_controller #(
    parameter int N       = 3,
    parameter int CMP_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    sar_search_controller_if.master       bus,
    output logic [1:0]                    state_o
);

    localparam int KW = (N > 0) ? $clog2(N + 1) : 1;
    localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
    localparam logic [KW-1:0] K_TOP     = KW'(N);
    localparam logic [CW-1:0] WAIT_INIT = CW'(CMP_LAT);
    localparam logic [N:0]    ONE       = (N + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TEST = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N:0]    trial_q, trial_d;
    logic [N:0]    result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] wait_q, wait_d;

    logic [N:0]    bit_k;
    logic [N:0]    decided;
    logic          one_hot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            k_q      <= K_TOP;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            k_q      <= k_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        k_d      = k_q;
        wait_d   = wait_q;

        bit_k   = ONE << k_q;
        // XOR is true for one or three flags set; the AND term rejects three.
        one_hot = (bus.cmp_gt ^ bus.cmp_lt ^ bus.cmp_eq)
                & ~(bus.cmp_gt & bus.cmp_lt & bus.cmp_eq);
        decided = bus.cmp_gt ? trial_q : (trial_q & ~bit_k);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_TEST;
                    k_d     = K_TOP;
                    trial_d = ONE << N;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    wait_d  = WAIT_INIT;
                end
            end
            S_TEST: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else if (!one_hot || bus.cmp_eq || (k_q == '0)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!one_hot) begin
                        err_d    = 1'b1;
                        result_d = trial_q & ~bit_k;
                    end else if (bus.cmp_eq) begin
                        result_d = trial_q;
                    end else begin
                        result_d = decided;
                    end
                end else begin
                    k_d     = k_q - 1'b1;
                    trial_d = decided | (bit_k >> 1);
                    wait_d  = WAIT_INIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.trial  = trial_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench for sar_search_controller: one instance with a combinational
// comparator, one with CMP_LAT=2 whose flags are garbage until they settle.
module tb_sar_search_controller;
    localparam int N    = 3;
    localparam int LAT1 = 2;
    localparam int LOGN = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_search_controller_if #(.N(N)) if0 ();
    sar_search_controller_if #(.N(N)) if1 ();
    logic [1:0] state0, state1;

    sar_search_controller #(.N(N), .CMP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .state_o(state0)
    );
    sar_search_controller #(.N(N), .CMP_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .state_o(state1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [N:0] unknown0 = '0;
    logic [N:0] unknown1 = '0;
    logic [N:0] bad_trial = '0;
    logic       bad_en = 1'b0;
    int         age1 = 0;
    logic [N:0] prev_trial1 = '0;
    logic       prev_busy1 = 1'b0;

    // Comparator models
    always @* begin
        if0.cmp_gt = unknown0 > if0.trial;
        if0.cmp_lt = unknown0 < if0.trial;
        if0.cmp_eq = unknown0 == if0.trial;
        if (bad_en && (if0.trial == bad_trial)) begin
            if0.cmp_gt = 1'b1;
            if0.cmp_lt = 1'b1;
            if0.cmp_eq = 1'b0;
        end
    end

    always @* begin
        if (age1 >= LAT1) begin
            if1.cmp_gt = unknown1 > if1.trial;
            if1.cmp_lt = unknown1 < if1.trial;
            if1.cmp_eq = unknown1 == if1.trial;
        end else begin
            if1.cmp_gt = 1'b1;
            if1.cmp_lt = 1'b1;
            if1.cmp_eq = 1'b0;
        end
    end

    always @(negedge clk) begin
        if ((if1.trial !== prev_trial1) || (if1.busy && !prev_busy1)) age1 = 0;
        else if (age1 < 7) age1 = age1 + 1;
        prev_trial1 = if1.trial;
        prev_busy1  = if1.busy;
    end

    logic [N:0] trial_log  [1:LOGN];
    logic [N:0] result_log [1:LOGN];
    logic       busy_log   [1:LOGN];
    logic       done_log   [1:LOGN];
    logic       err_log    [1:LOGN];
    logic [1:0] state_log  [1:LOGN];

    // Driver: start raised before the sampling edge (cycle 0), then one log
    // entry per cycle taken at the falling edge; start stays high while c < hold.
    task automatic run(input int sel, input logic [N:0] u, input int ncyc, input int hold);
        if (sel == 0) unknown0 = u; else unknown1 = u;
        @(negedge clk);
        if (sel == 0) if0.start = 1'b1; else if1.start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (sel == 0) begin
                trial_log[c] = if0.trial;  result_log[c] = if0.result;
                busy_log[c]  = if0.busy;   done_log[c]   = if0.done;
                err_log[c]   = if0.err;    state_log[c]  = state0;
            end else begin
                trial_log[c] = if1.trial;  result_log[c] = if1.result;
                busy_log[c]  = if1.busy;   done_log[c]   = if1.done;
                err_log[c]   = if1.err;    state_log[c]  = state1;
            end
            if (c >= hold) begin
                if0.start = 1'b0;
                if1.start = 1'b0;
            end
        end
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    function automatic int first_done(input int ncyc);
        for (int c = 1; c <= ncyc; c++) if (done_log[c]) return c;
        return 0;
    endfunction

    function automatic int count_done(input int ncyc);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (done_log[c]) n++;
        return n;
    endfunction

    function automatic int count_busy(input int ncyc);
        int n = 0;
        for (int c = 1; c <= ncyc; c++) if (busy_log[c]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (if0.trial !== 4'd0) begin n_fail++; $display("FAIL reset_trial0: got %0d expected 0", if0.trial); end
        n_checks++; if (if0.result !== 4'd0) begin n_fail++; $display("FAIL reset_result0: got %0d expected 0", if0.result); end
        n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0: got %b expected 0", if0.busy); end
        n_checks++; if (if0.done !== 1'b0) begin n_fail++; $display("FAIL reset_done0: got %b expected 0", if0.done); end
        n_checks++; if (if0.err !== 1'b0) begin n_fail++; $display("FAIL reset_err0: got %b expected 0", if0.err); end
        n_checks++; if (state0 !== 2'd0) begin n_fail++; $display("FAIL reset_state0: got %0d expected 0", state0); end
        n_checks++; if (if1.trial !== 4'd0) begin n_fail++; $display("FAIL reset_trial1: got %0d expected 0", if1.trial); end
        n_checks++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b expected 0", if1.busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (state0 !== 2'd0 || if0.busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: state %0d busy %b expected 0 0", state0, if0.busy); end
    endtask

    task automatic test_search_vectors();
        logic [N:0] uv [3] = '{4'd5, 4'd0, 4'd15};
        int         et [3][4] = '{'{8, 4, 6, 5}, '{8, 4, 2, 1}, '{8, 12, 14, 15}};
        int         ov;
        for (int v = 0; v < 3; v++) begin
            run(0, uv[v], 8, 0);
            for (int c = 1; c <= 4; c++) begin
                n_checks++;
                if (trial_log[c] !== 4'(et[v][c-1]) || busy_log[c] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL search_trial u=%0d cyc=%0d: got trial %0d busy %b expected %0d 1", uv[v], c, trial_log[c], busy_log[c], et[v][c-1]);
                end
            end
            n_checks++; if (first_done(8) !== 5 || count_done(8) !== 1) begin n_fail++; $display("FAIL search_done u=%0d: got cycle %0d count %0d expected 5 1", uv[v], first_done(8), count_done(8)); end
            n_checks++; if (result_log[5] !== uv[v] || err_log[5] !== 1'b0) begin n_fail++; $display("FAIL search_result u=%0d: got %0d err %b expected %0d 0", uv[v], result_log[5], err_log[5], uv[v]); end
            ov = 0;
            for (int c = 1; c <= 8; c++) if (busy_log[c] && done_log[c]) ov++;
            n_checks++; if (ov !== 0 || busy_log[5] !== 1'b0) begin n_fail++; $display("FAIL busy_done_overlap u=%0d: got overlap %0d busy5 %b expected 0 0", uv[v], ov, busy_log[5]); end
        end
    endtask

    task automatic test_early_eq();
        run(0, 4'd8, 6, 0);
        n_checks++; if (first_done(6) !== 2 || count_done(6) !== 1) begin n_fail++; $display("FAIL early_eq_done: got cycle %0d count %0d expected 2 1", first_done(6), count_done(6)); end
        n_checks++; if (count_busy(6) !== 1) begin n_fail++; $display("FAIL early_eq_busy: got %0d busy cycles expected 1", count_busy(6)); end
        n_checks++; if (result_log[2] !== 4'd8) begin n_fail++; $display("FAIL early_eq_result: got %0d expected 8", result_log[2]); end
        // eq at k=1 saves one cycle relative to the full search
        run(0, 4'd6, 6, 0);
        n_checks++; if (first_done(6) !== 4 || result_log[4] !== 4'd6) begin n_fail++; $display("FAIL eq_k1: got cycle %0d result %0d expected 4 6", first_done(6), result_log[4]); end
    endtask

    task automatic test_cmp_latency();
        int et [12] = '{8, 8, 8, 12, 12, 12, 10, 10, 10, 11, 11, 11};
        run(1, 4'd11, 16, 0);
        for (int c = 1; c <= 12; c++) begin
            n_checks++;
            if (trial_log[c] !== 4'(et[c-1]) || busy_log[c] !== 1'b1) begin
                n_fail++;
                $display("FAIL lat_trial cyc=%0d: got trial %0d busy %b expected %0d 1", c, trial_log[c], busy_log[c], et[c-1]);
            end
        end
        n_checks++; if (first_done(16) !== 13 || count_done(16) !== 1) begin n_fail++; $display("FAIL lat_done: got cycle %0d count %0d expected 13 1", first_done(16), count_done(16)); end
        n_checks++; if (result_log[13] !== 4'd11 || err_log[13] !== 1'b0) begin n_fail++; $display("FAIL lat_result: got %0d err %b expected 11 0", result_log[13], err_log[13]); end
    endtask

    task automatic test_error();
        bad_en = 1'b1;
        bad_trial = 4'd12;
        run(0, 4'd11, 6, 0);
        n_checks++; if (first_done(6) !== 3 || count_done(6) !== 1) begin n_fail++; $display("FAIL err_done: got cycle %0d count %0d expected 3 1", first_done(6), count_done(6)); end
        n_checks++; if (err_log[3] !== 1'b1 || result_log[3] !== 4'd8) begin n_fail++; $display("FAIL err_result: got err %b result %0d expected 1 8", err_log[3], result_log[3]); end
        n_checks++; if (err_log[6] !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b expected 1", err_log[6]); end
        bad_en = 1'b0;
        run(0, 4'd11, 8, 0);
        n_checks++; if (err_log[1] !== 1'b0 || result_log[1] !== 4'd8) begin n_fail++; $display("FAIL err_clear: got err %b result %0d expected 0 8", err_log[1], result_log[1]); end
        n_checks++; if (first_done(8) !== 5 || result_log[5] !== 4'd11 || err_log[5] !== 1'b0) begin n_fail++; $display("FAIL err_recover: got cycle %0d result %0d err %b expected 5 11 0", first_done(8), result_log[5], err_log[5]); end
    endtask

    task automatic test_ignore_start();
        int et [4] = '{8, 4, 6, 5};
        run(0, 4'd5, 8, 6);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (trial_log[c] !== 4'(et[c-1])) begin n_fail++; $display("FAIL ign_trial cyc=%0d: got %0d expected %0d", c, trial_log[c], et[c-1]); end
        end
        n_checks++; if (first_done(8) !== 5 || count_done(8) !== 1) begin n_fail++; $display("FAIL ign_done: got cycle %0d count %0d expected 5 1", first_done(8), count_done(8)); end
        n_checks++; if (busy_log[6] !== 1'b0 || state_log[6] !== 2'd0 || busy_log[7] !== 1'b0) begin n_fail++; $display("FAIL ign_restart: got busy6 %b state6 %0d busy7 %b expected 0 0 0", busy_log[6], state_log[6], busy_log[7]); end
    endtask

    task automatic test_reset_mid();
        unknown0 = 4'd9;
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (if0.trial !== 4'd0 || if0.busy !== 1'b0 || state0 !== 2'd0) begin n_fail++; $display("FAIL mid_reset: got trial %0d busy %b state %0d expected 0 0 0", if0.trial, if0.busy, state0); end
        n_checks++; if (if0.result !== 4'd0 || if0.err !== 1'b0 || if0.done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out: got result %0d err %b done %b expected 0 0 0", if0.result, if0.err, if0.done); end
        @(negedge clk);
        rst = 1'b0;
        run(0, 4'd9, 8, 0);
        n_checks++; if (first_done(8) !== 5 || result_log[5] !== 4'd9) begin n_fail++; $display("FAIL mid_recover: got cycle %0d result %0d expected 5 9", first_done(8), result_log[5]); end
    endtask

    initial begin
        test_reset();
        test_search_vectors();
        test_early_eq();
        test_cmp_latency();
        test_error();
        test_ignore_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
